// File: rtl/iref_seq_pkg.sv
// Shared constants for the current-reference sequencer: register map,
// CTRL bit positions, FSM state codes and power-on durations.
package iref_seq_pkg;

  localparam int ADDR_CTRL    = 0;
  localparam int ADDR_CHG_CYC = 1;
  localparam int ADDR_SET_CYC = 2;
  localparam int ADDR_STATUS  = 3;

  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 1;

  localparam int DEF_CHG_CYC = 16;
  localparam int DEF_SET_CYC = 8;

  typedef enum logic [1:0] {
    ST_OFF    = 2'b00,
    ST_CHARGE = 2'b01,
    ST_SETTLE = 2'b10,
    ST_ON     = 2'b11
  } state_e;

endpackage

// File: rtl/iref_seq_cnt.sv
// Loadable down-counter for phase durations; "last" flags count <= 1 so a
// zero duration still yields one cycle.
module iref_seq_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                        cnt_d = '0;
    else if (load_i)                  cnt_d = load_val_i;
    else if (en_i && cnt_q != '0)     cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign last_o = (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/iref_seq.sv
// Current-reference power-up sequencer: CPU register file, OFF->CHARGE->
// SETTLE->ON FSM and registered pd/charge/done outputs.
module iref_seq
  import iref_seq_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int IREF_SEQ_ADDR_W = 2,
  parameter int CNT_W           = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid,
  input  logic [IREF_SEQ_ADDR_W-1:0] address,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       wstrb,
  output logic [DATA_W-1:0]          rdata,
  output logic                       ready,
  output logic                       pd,
  output logic                       charge,
  output logic                       done
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] chg_q, set_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic             ready_q, pd_q, pd_d, charge_q, charge_d, done_q, done_d;
  logic             cnt_clr, cnt_load, cnt_en, cnt_last;
  logic [CNT_W-1:0] cnt_val;
  logic             wr, wr_ctrl, start, stop, busy, on;
  logic             unused_wdata;

  assign wr      = valid && wstrb;
  assign wr_ctrl = wr && (address == IREF_SEQ_ADDR_W'(ADDR_CTRL));
  assign stop    = wr_ctrl && wdata[CTRL_STOP];
  assign start   = wr_ctrl && wdata[CTRL_START];
  assign busy    = (state_q == ST_CHARGE) || (state_q == ST_SETTLE);
  assign on      = (state_q == ST_ON);
  assign unused_wdata = ^wdata;

  // Duration registers; a new value only matters at the next counter load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chg_q <= CNT_W'(DEF_CHG_CYC);
      set_q <= CNT_W'(DEF_SET_CYC);
    end else if (wr) begin
      if (address == IREF_SEQ_ADDR_W'(ADDR_CHG_CYC)) chg_q <= wdata[CNT_W-1:0];
      if (address == IREF_SEQ_ADDR_W'(ADDR_SET_CYC)) set_q <= wdata[CNT_W-1:0];
    end
  end

  always_comb begin
    rdata_d = '0;
    if (valid && !wstrb) begin
      if (address == IREF_SEQ_ADDR_W'(ADDR_CHG_CYC))     rdata_d = DATA_W'(chg_q);
      else if (address == IREF_SEQ_ADDR_W'(ADDR_SET_CYC)) rdata_d = DATA_W'(set_q);
      else if (address == IREF_SEQ_ADDR_W'(ADDR_STATUS))
        rdata_d = DATA_W'({state_q, on, busy});
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_val  = chg_q;
    done_d   = 1'b0;
    if (stop) begin
      state_d = ST_OFF;
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_OFF: if (start) begin
          state_d  = ST_CHARGE;
          cnt_load = 1'b1;
        end
        ST_CHARGE: if (cnt_last) begin
          state_d  = ST_SETTLE;
          cnt_load = 1'b1;
          cnt_val  = set_q;
        end else cnt_en = 1'b1;
        ST_SETTLE: if (cnt_last) begin
          state_d = ST_ON;
          cnt_clr = 1'b1;
          done_d  = 1'b1;
        end else cnt_en = 1'b1;
        ST_ON: ;
        default: state_d = ST_OFF;
      endcase
    end
    // Outputs are decoded from the next state so they line up with state_q.
    pd_d     = (state_d == ST_OFF);
    charge_d = (state_d == ST_CHARGE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_OFF;
      pd_q     <= 1'b1;
      charge_q <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      pd_q     <= pd_d;
      charge_q <= charge_d;
      done_q   <= done_d;
      ready_q  <= valid;
      rdata_q  <= rdata_d;
    end
  end

  iref_seq_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (cnt_clr),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .en_i       (cnt_en),
    .last_o     (cnt_last)
  );

  assign rdata  = rdata_q;
  assign ready  = ready_q;
  assign pd     = pd_q;
  assign charge = charge_q;
  assign done   = done_q;

endmodule

// File: tb/tb_iref_seq.sv
// Directed bench for iref_seq: register access, phase lengths, STOP/START
// corner cases and asynchronous reset mid-sequence.
module tb_iref_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [1:0]  address = '0;
  logic [31:0] wdata = '0;
  logic        wstrb = 1'b0;
  logic [31:0] rdata;
  logic        ready, pd, charge, done;

  int n_chk = 0;
  int n_err = 0;

  iref_seq dut (
    .clk(clk), .rst(rst), .valid(valid), .address(address), .wdata(wdata),
    .wstrb(wstrb), .rdata(rdata), .ready(ready), .pd(pd), .charge(charge),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    valid = 1'b1; wstrb = 1'b1; address = a; wdata = d;
    @(posedge clk); #1;
    valid = 1'b0; wstrb = 1'b0; wdata = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    valid = 1'b1; wstrb = 1'b0; address = a;
    @(posedge clk); #1;
    valid = 1'b0;
    chk("rd_ready", {31'd0, ready}, 32'd1);
    d = rdata;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Count consecutive samples in CHARGE, advancing one cycle per sample.
  task automatic cnt_charge(output int n);
    n = 0;
    while (charge === 1'b1 && pd === 1'b0 && n < 100) begin n++; step(); end
  endtask

  task automatic cnt_settle(output int n);
    n = 0;
    while (charge === 1'b0 && pd === 1'b0 && done === 1'b0 && n < 100) begin n++; step(); end
  endtask

  task automatic watch_no_done(input string tag, input int cycles);
    logic seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      if (done !== 1'b0) seen = 1'b1;
      step();
    end
    chk(tag, {31'd0, seen}, 32'd0);
  endtask

  logic [31:0] d;
  int n;

  initial begin
    // Reset values
    #12;
    chk("rst_pd", {31'd0, pd}, 32'd1);
    chk("rst_charge", {31'd0, charge}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    rd(2'd3, d); chk("rst_status", d, 32'd0);
    rd(2'd1, d); chk("rst_chg", d, 32'd16);
    rd(2'd2, d); chk("rst_set", d, 32'd8);
    rd(2'd0, d); chk("ctrl_rd0", d, 32'd0);
    chk("ready_drop", {31'd0, ready}, 32'd1);
    step();
    chk("ready_low", {31'd0, ready}, 32'd0);

    // Nominal sequence 5/3
    wr(2'd1, 32'd5); wr(2'd2, 32'd3); wr(2'd0, 32'h1);
    cnt_charge(n); chk("nom_charge_len", n, 32'd5);
    cnt_settle(n); chk("nom_settle_len", n, 32'd3);
    chk("nom_done", {31'd0, done}, 32'd1);
    step();
    chk("nom_done_1cyc", {31'd0, done}, 32'd0);
    rd(2'd3, d); chk("nom_status_on", d, 32'hE);

    // Zero durations
    wr(2'd0, 32'h2);
    chk("stop_pd", {31'd0, pd}, 32'd1);
    rd(2'd3, d); chk("stop_status", d, 32'd0);
    wr(2'd1, 32'd0); wr(2'd2, 32'd0); wr(2'd0, 32'h1);
    cnt_charge(n); chk("zero_charge_len", n, 32'd1);
    cnt_settle(n); chk("zero_settle_len", n, 32'd1);
    chk("zero_done", {31'd0, done}, 32'd1);
    rd(2'd3, d); chk("zero_status_on", d, 32'hE);

    // STOP at charge cycle 2
    wr(2'd0, 32'h2);
    wr(2'd1, 32'd5); wr(2'd0, 32'h1);
    rd(2'd3, d); chk("chg_status", d, 32'h5);
    wr(2'd0, 32'h2);
    chk("abort_pd", {31'd0, pd}, 32'd1);
    chk("abort_charge", {31'd0, charge}, 32'd0);
    watch_no_done("abort_no_done", 12);
    rd(2'd3, d); chk("abort_status", d, 32'd0);

    // START while ON ignored
    wr(2'd1, 32'd1); wr(2'd2, 32'd1); wr(2'd0, 32'h1);
    step(); step(); step();
    rd(2'd3, d); chk("on_status", d, 32'hE);
    wr(2'd0, 32'h1);
    rd(2'd3, d); chk("on_restart_status", d, 32'hE);
    chk("on_restart_pd", {31'd0, pd}, 32'd0);

    // START+STOP together from OFF
    wr(2'd0, 32'h2);
    wr(2'd0, 32'h3);
    chk("both_pd", {31'd0, pd}, 32'd1);
    rd(2'd3, d); chk("both_status", d, 32'd0);

    // CHG_CYC rewrite mid-charge does not shorten current run
    wr(2'd1, 32'd5); wr(2'd2, 32'd2); wr(2'd0, 32'h1);
    wr(2'd1, 32'd2);
    cnt_charge(n); chk("rewrite_charge_rest", n, 32'd4);
    rd(2'd1, d); chk("rewrite_chg_rd", d, 32'd2);

    // Reset during SETTLE
    wr(2'd0, 32'h2);
    wr(2'd1, 32'd2); wr(2'd2, 32'd5); wr(2'd0, 32'h1);
    step(); step();
    chk("pre_rst_settle", {30'd0, pd, charge}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("async_pd", {31'd0, pd}, 32'd1);
    chk("async_charge", {31'd0, charge}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    watch_no_done("post_rst_no_done", 12);
    rd(2'd3, d); chk("post_rst_status", d, 32'd0);
    rd(2'd1, d); chk("post_rst_chg", d, 32'd16);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/iref_seq.md
IREF_SEQ -- requirements
Module: iref_seq

Interface
REQ-001 Parameter DATA_W, default 32, CPU data width.
REQ-002 Parameter IREF_SEQ_ADDR_W, default 2, register address width.
REQ-003 Parameter CNT_W, default 16, width of the duration counters; CNT_W <= DATA_W.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 valid  input  1  CPU access request.
REQ-007 address  input  IREF_SEQ_ADDR_W  register select.
REQ-008 wdata  input  DATA_W  write data.
REQ-009 wstrb  input  1  1 = write, 0 = read.
REQ-010 rdata  output  DATA_W  read data, valid while ready=1.
REQ-011 ready  output  1  access acknowledge.
REQ-012 pd  output  1  current-reference power-down, 1 = powered down.
REQ-013 charge  output  1  current-reference fast-charge enable.
REQ-014 done  output  1  one-cycle pulse when the reference becomes usable.

Function
REQ-015 Register map: 0 CTRL (write-only: bit0 START, bit1 STOP); 1 CHG_CYC (bits CNT_W-1:0); 2 SET_CYC (bits CNT_W-1:0); 3 STATUS (read-only: bit0 busy, bit1 on, bits 3:2 state code).
REQ-016 ready shall equal valid registered by one cycle; held valid yields ready held high; no wait states.
REQ-017 Reads shall return the addressed register zero-extended to DATA_W on the cycle ready=1; CTRL reads return 0.
REQ-018 Writes shall take effect on the clock edge where valid=1 and wstrb=1; writes to STATUS are ignored.
REQ-019 FSM states: OFF (00), CHARGE (01), SETTLE (10), ON (11).
REQ-020 OFF: pd=1, charge=0; START write moves to CHARGE and loads the counter with CHG_CYC.
REQ-021 CHARGE: pd=0, charge=1; counter decrements each cycle; at count 1 (or 0) moves to SETTLE and loads the counter with SET_CYC.
REQ-022 SETTLE: pd=0, charge=0; counter decrements; at count 1 (or 0) moves to ON and pulses done for exactly one cycle.
REQ-023 ON: pd=0, charge=0; remains until STOP.
REQ-024 A duration value N shall give exactly max(N,1) cycles in the corresponding state.
REQ-025 STOP write in any state shall move to OFF on that edge (pd=1, charge=0 from the next cycle); the counter is cleared.
REQ-026 START and STOP in the same write: STOP wins.
REQ-027 START while not in OFF shall be ignored.
REQ-028 CHG_CYC/SET_CYC writes during a sequence shall not affect the running count; they apply at the next load.
REQ-029 busy = state is CHARGE or SETTLE; on = state is ON.
REQ-030 pd, charge and done shall be registered outputs (no combinational path from CPU inputs).

Reset
REQ-031 On rst: state OFF, pd=1, charge=0, done=0, ready=0, rdata=0, counter=0.
REQ-032 On rst: CHG_CYC=16, SET_CYC=8.
REQ-033 Reset asserted mid-sequence shall force the reset values asynchronously; no done pulse follows deassertion.

Structure
REQ-034 Shared header iref_seq.vh shall hold register addresses, CTRL bit positions, state codes and default durations.
REQ-035 One sub-module, iref_seq_cnt: loadable CNT_W down-counter with load, enable, clear and a "last" flag (count <= 1).
REQ-036 Top level holds the CPU register file, FSM and output registers; target 150-300 lines total.

Verification
REQ-037 Reset, then read STATUS -> rdata=0, pd=1, charge=0; read CHG_CYC -> 16.
REQ-038 Write CHG_CYC=5, SET_CYC=3, START -> charge=1 for exactly 5 cycles, then 3 cycles with pd=0, charge=0, then done=1 for one cycle, STATUS=0xE (on=1, state=11).
REQ-039 CHG_CYC=0, SET_CYC=0, START -> 1 cycle CHARGE, 1 cycle SETTLE, done pulse; no zero-length state or counter wrap.
REQ-040 START, STOP during CHARGE at cycle 2 -> pd=1, charge=0 next cycle, no done; a second START during ON is ignored (STATUS unchanged).
REQ-041 Write CTRL=0x3 from OFF -> state stays OFF, pd=1; write CHG_CYC=2 mid-CHARGE -> current CHARGE length unchanged.
REQ-042 Assert rst during SETTLE -> pd=1, charge=0 immediately; after release STATUS=0 and done stays 0.
